exec_alu_stage: RTL and testbench
=================================

Name: exec_alu_stage

Overview:
- Execute stage directly downstream of src2shift. Consumes the shifted operand2 (src2), the shifter carry-out and the was_shifted flag.
- Combines src2 with Rn through a 16-opcode data-processing ALU or a 32-cycle iterative multiplier.
- Evaluates the instruction condition code against an internal NZCV register. Updates the flags and presents a registered result to writeback over a valid/ready handshake.

Parameters:
MUL_CYCLES, 32, iterations of the shift-add multiplier (one per multiplier bit)
XLEN, 32, datapath width

Ports:
CLOCK_50  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
in_valid  in  1  upstream operands valid
in_ready  out  1  stage can accept an instruction this cycle
CTRL_aluop  in  4  data-processing opcode (AND..MVN, standard ARM encoding)
CTRL_setflags  in  1  S bit
CTRL_cond  in  4  condition field
CTRL_mul  in  1  1 = MUL (Rd = Rn*src2), CTRL_aluop ignored
RF_Rn  in  XLEN  first operand
src2  in  XLEN  second operand from src2shift
carryBit  in  1  shifter carry-out
was_shifted  in  1  shifter actually shifted/rotated
out_valid  out  1  result register holds an instruction
out_ready  in  1  writeback accepts result
alu_result  out  XLEN  registered result
write_en  out  1  condition passed and opcode writes Rd (not TST/TEQ/CMP/CMN)
flags  out  4  NZCV register {N,Z,C,V}

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; out_valid=0, alu_result=0, write_en=0, flags=0000, multiplier registers=0. Reset mid-MUL aborts it; nothing is reported.
- Accept: on a rising edge when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Condition: evaluated combinationally at accept against the current flags. EQ..LE use ARM semantics; AL(1110) and 1111 always pass.
- A failing condition still produces an output beat with write_en=0, alu_result=0 and flags unchanged. Ordering downstream is preserved.
- ALU path, latency 1: the accept edge loads alu_result and write_en and sets out_valid=1.
  - When S=1 and the condition passes, flags update on the same edge. The next accepted instruction sees the new flags.
- Arithmetic (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): 33-bit add.
  - C = carry out; for subtraction C = NOT borrow.
  - V = signed overflow.
  - ADC/SBC/RSC use the current C.
- Logical (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - C = carryBit if was_shifted, else C unchanged.
  - V unchanged.
- N = result[XLEN-1]; Z = (result==0).
- FSM:
  - IDLE: accept; on MUL go to MUL_BUSY.
  - MUL_BUSY: one multiplicand/multiplier bit per cycle, counter 0..MUL_CYCLES-1, in_ready=0. After the last iteration go to MUL_DONE.
  - MUL_DONE: load alu_result = low XLEN bits of the product, out_valid=1. If S=1 and the condition passed, update N and Z; C and V unchanged. Return to IDLE.
  - MUL latency is MUL_CYCLES+1 cycles from the accept edge to out_valid.
  - A MUL whose condition fails skips MUL_BUSY and completes in 1 cycle like a failed ALU op.
- Output hold: while out_valid && !out_ready, alu_result, write_en and out_valid stay stable. The result clears out_valid on an out_ready handshake unless a new instruction is accepted on the same edge; simultaneous handshake-out and accept is allowed (full throughput).
- Width rules: all results are truncated to XLEN. Flags derive from the truncated result plus the 33rd carry bit.

Decomposition:
- Shared package cpu_pkg:
  - aluop_e enum (16 opcodes)
  - cond_e enum
  - flags_t struct {N,Z,C,V}
  - exec_state_e {IDLE, MUL_BUSY, MUL_DONE}
  - function cond_pass(cond, flags), shared with the branch unit
- Natural sub-module: seq_multiplier (start/done, shift-add, MUL_CYCLES parameter), instantiated once. The ALU and flag logic stay combinational inside exec_alu_stage.

Test Plan:
- ADD S=1, AL: Rn=5, src2=7 -> one cycle later out_valid=1, alu_result=12, write_en=1, flags=0000.
- SUBS: Rn=3, src2=3 -> result 0, flags=0110 (Z=1, C=1). Then ADD, cond EQ: Rn=1, src2=1 -> result 2, write_en=1. Then cond NE -> write_en=0, flags still 0110.
- ADDS: Rn=0x7FFFFFFF, src2=1 -> 0x80000000, flags=1001. MOVS: src2=0x80000000, carryBit=1, was_shifted=1 -> C=1, V stays 1. Repeat with was_shifted=0 -> C unchanged.
- MUL S=1: Rn=1234, src2=5678 -> in_ready=0 for MUL_CYCLES cycles; out_valid after 33 cycles; alu_result=7006652; N=0, Z=0, C/V unchanged.
- Backpressure: out_ready=0 with two queued ADDs -> first result held stable, in_ready=0. Raise out_ready -> first beat taken and second accepted on the same edge, no bubble.
- Reset mid-MUL: assert RESET_N=0 at iteration 10 -> immediate out_valid=0 and flags=0000. After release, in_ready=1 and a new ADD of 2+2 returns 4.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the execute stage and the branch unit.
//   aluop_e      : 16 data-processing opcodes, standard ARM encoding
//   cond_e       : 4-bit condition field encodings
//   flags_t      : packed NZCV register, bit 3 = N ... bit 0 = V
//   exec_state_e : execute stage sequencing states
//   cond_pass()  : evaluates a condition field against a flag set
//   writes_rd()  : 0 for the compare-only opcodes (TST/TEQ/CMP/CMN)
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } aluop_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } exec_state_e;

  // The 1111 encoding is treated as "always" rather than "never".
  function automatic logic cond_pass(input cond_e cond, input flags_t f);
    logic pass;
    case (cond)
      COND_EQ: pass = f.z;
      COND_NE: pass = !f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = !f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = !f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = !f.v;
      COND_HI: pass = f.c && !f.z;
      COND_LS: pass = !f.c || f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = !f.z && (f.n == f.v);
      COND_LE: pass = f.z || (f.n != f.v);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  function automatic logic writes_rd(input aluop_e op);
    return !((op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN));
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier: one multiplier bit per clock.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : load operands and begin (ignored semantics while busy
//                      are the caller's responsibility)
//   multiplicand     : XLEN-bit operand shifted left each iteration
//   multiplier       : XLEN-bit operand consumed LSB first
//   done             : high in the cycle whose edge performs the last iteration
//   product          : low XLEN bits of the running product
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  // Only the low XLEN product bits are kept, so bits shifted out of the
  // multiplicand can never reach the result and are simply dropped.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (count_q == LAST_ITER) begin
        count_d = '0;
        busy_d  = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign done    = busy_q && (count_q == LAST_ITER);
  assign product = acc_q;

endmodule

// File: rtl/exec_alu_stage.sv
// -----------------------------------------------------------------------------
// exec_alu_stage
// Execute stage after src2shift: data-processing ALU or iterative MUL,
// condition evaluation against an internal NZCV register, registered result
// handed to writeback over valid/ready.
//   CLOCK_50, RESET_N        : clock (rising edge), async active-low reset
//   in_valid / in_ready      : upstream handshake
//   CTRL_aluop/setflags/cond : opcode, S bit, condition field
//   CTRL_mul                 : 1 selects MUL (Rd = Rn * src2)
//   RF_Rn, src2              : operands (src2 already shifted)
//   carryBit, was_shifted    : shifter carry-out and whether it is meaningful
//   out_valid / out_ready    : writeback handshake
//   alu_result, write_en     : registered result and Rd write enable
//   flags                    : NZCV register {N,Z,C,V}
// -----------------------------------------------------------------------------
module exec_alu_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      CTRL_aluop,
  input  logic            CTRL_setflags,
  input  logic [3:0]      CTRL_cond,
  input  logic            CTRL_mul,
  input  logic [XLEN-1:0] RF_Rn,
  input  logic [XLEN-1:0] src2,
  input  logic            carryBit,
  input  logic            was_shifted,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            write_en,
  output logic [3:0]      flags
);

  exec_state_e     state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic            write_en_q, write_en_d;
  flags_t          flags_q, flags_d;
  logic            mul_setflags_q, mul_setflags_d;

  aluop_e          op;
  logic            accept;
  logic            cond_ok;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  logic [XLEN-1:0] add_a, add_b;
  logic            add_cin;
  logic            is_arith;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] logic_res;
  logic [XLEN-1:0] alu_res;
  flags_t          alu_flags;

  assign op       = aluop_e'(CTRL_aluop);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign cond_ok  = cond_pass(cond_e'(CTRL_cond), flags_q);

  // Every arithmetic opcode is folded onto one XLEN+1 bit adder: subtraction
  // is a + ~b + 1, so the adder carry-out is directly ARM's NOT-borrow C.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    logic_res = '0;
    case (op)
      OP_SUB, OP_CMP: begin
        add_a = RF_Rn;  add_b = ~src2;  add_cin = 1'b1;       is_arith = 1'b1;
      end
      OP_RSB: begin
        add_a = src2;   add_b = ~RF_Rn; add_cin = 1'b1;       is_arith = 1'b1;
      end
      OP_ADD, OP_CMN: begin
        add_a = RF_Rn;  add_b = src2;   add_cin = 1'b0;       is_arith = 1'b1;
      end
      OP_ADC: begin
        add_a = RF_Rn;  add_b = src2;   add_cin = flags_q.c;  is_arith = 1'b1;
      end
      OP_SBC: begin
        add_a = RF_Rn;  add_b = ~src2;  add_cin = flags_q.c;  is_arith = 1'b1;
      end
      OP_RSC: begin
        add_a = src2;   add_b = ~RF_Rn; add_cin = flags_q.c;  is_arith = 1'b1;
      end
      OP_AND, OP_TST: logic_res = RF_Rn & src2;
      OP_EOR, OP_TEQ: logic_res = RF_Rn ^ src2;
      OP_ORR:         logic_res = RF_Rn | src2;
      OP_MOV:         logic_res = src2;
      OP_BIC:         logic_res = RF_Rn & ~src2;
      OP_MVN:         logic_res = ~src2;
      default:        logic_res = '0;
    endcase
  end

  assign sum     = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};
  assign alu_res = is_arith ? sum[XLEN-1:0] : logic_res;

  // Overflow is judged on the adder's actual inputs, after any inversion.
  always_comb begin
    alu_flags   = flags_q;
    alu_flags.n = alu_res[XLEN-1];
    alu_flags.z = (alu_res == '0);
    if (is_arith) begin
      alu_flags.c = sum[XLEN];
      alu_flags.v = (add_a[XLEN-1] == add_b[XLEN-1]) &&
                    (sum[XLEN-1] != add_a[XLEN-1]);
    end else if (was_shifted) begin
      alu_flags.c = carryBit;
    end
  end

  seq_multiplier #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk          (CLOCK_50),
    .rst_n        (RESET_N),
    .start        (mul_start),
    .multiplicand (RF_Rn),
    .multiplier   (src2),
    .done         (mul_done),
    .product      (mul_product)
  );

  // A beat leaving on out_ready clears out_valid unless something refills
  // the register on the same edge. A failed condition (MUL included) always
  // yields an immediate empty beat so writeback still sees program order.
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    alu_result_d   = alu_result_q;
    write_en_d     = write_en_q;
    flags_d        = flags_q;
    mul_setflags_d = mul_setflags_q;
    mul_start      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cond_ok) begin
            out_valid_d  = 1'b1;
            alu_result_d = '0;
            write_en_d   = 1'b0;
          end else if (CTRL_mul) begin
            mul_start      = 1'b1;
            mul_setflags_d = CTRL_setflags;
            state_d        = MUL_BUSY;
          end else begin
            out_valid_d  = 1'b1;
            alu_result_d = alu_res;
            write_en_d   = writes_rd(op);
            if (CTRL_setflags) begin
              flags_d = alu_flags;
            end
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        out_valid_d  = 1'b1;
        alu_result_d = mul_product;
        write_en_d   = 1'b1;
        if (mul_setflags_q) begin
          flags_d.n = mul_product[XLEN-1];
          flags_d.z = (mul_product == '0);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      alu_result_q   <= '0;
      write_en_q     <= 1'b0;
      flags_q        <= '0;
      mul_setflags_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      alu_result_q   <= alu_result_d;
      write_en_q     <= write_en_d;
      flags_q        <= flags_d;
      mul_setflags_q <= mul_setflags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign write_en   = write_en_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_exec_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_alu_stage
// Self-checking bench for exec_alu_stage: directed vector table, hand-written
// MUL / backpressure / reset sequences, and randomized instructions compared
// against an arithmetic reference model of the flag and result rules.
// -----------------------------------------------------------------------------
module tb_exec_alu_stage;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  logic            CLOCK_50 = 1'b0;
  logic            RESET_N  = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      CTRL_aluop = 4'h0;
  logic            CTRL_setflags = 1'b0;
  logic [3:0]      CTRL_cond = 4'hE;
  logic            CTRL_mul = 1'b0;
  logic [XLEN-1:0] RF_Rn = '0;
  logic [XLEN-1:0] src2 = '0;
  logic            carryBit = 1'b0;
  logic            was_shifted = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] alu_result;
  logic            write_en;
  logic [3:0]      flags;

  always #10 CLOCK_50 = ~CLOCK_50;

  exec_alu_stage #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .CTRL_aluop    (CTRL_aluop),
    .CTRL_setflags (CTRL_setflags),
    .CTRL_cond     (CTRL_cond),
    .CTRL_mul      (CTRL_mul),
    .RF_Rn         (RF_Rn),
    .src2          (src2),
    .carryBit      (carryBit),
    .was_shifted   (was_shifted),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .write_en      (write_en),
    .flags         (flags)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        s;
    logic [3:0]  cond;
    logic [31:0] rn;
    logic [31:0] b;
    logic        cb;
    logic        ws;
    logic [31:0] exp_res;
    logic        exp_wen;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: flags as {N,Z,C,V} plus the last expected beat.
  logic [3:0]  m_flags = 4'b0000;
  logic [31:0] m_res;
  logic        m_wen;
  int          m_lat;

  // Opcode and condition constants used by the stimulus.
  localparam logic [3:0] AND_ = 4'h0, EOR_ = 4'h1, SUB_ = 4'h2, RSB_ = 4'h3;
  localparam logic [3:0] ADD_ = 4'h4, ADC_ = 4'h5, SBC_ = 4'h6;
  localparam logic [3:0] TEQ_ = 4'h9, CMP_ = 4'hA, ORR_ = 4'hC;
  localparam logic [3:0] MOV_ = 4'hD, BIC_ = 4'hE, MVN_ = 4'hF;
  localparam logic [3:0] EQ = 4'h0, NE = 4'h1, HI = 4'h8, LS = 4'h9;
  localparam logic [3:0] GE = 4'hA, LT = 4'hB, GT = 4'hC, AL = 4'hE;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic bit modelCond(input logic [3:0] cond);
    bit n, z, c, v;
    {n, z, c, v} = m_flags;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Results and flags come from exact 64-bit integer arithmetic: C is
  // "unsigned result did not wrap / no borrow", V is "signed result does not
  // fit in 32 bits".
  task automatic modelExec(input logic [3:0] op, input logic s, input logic [3:0] cond,
                           input logic mul, input logic [31:0] rn, input logic [31:0] b,
                           input logic cb, input logic ws);
    longint au, bu, as_, bs, r, sr, cin;
    bit n, z, c, v, arith;
    logic [31:0] res;
    {n, z, c, v} = m_flags;
    m_lat = 0;
    if (!modelCond(cond)) begin
      m_res = 32'd0;
      m_wen = 1'b0;
      return;
    end
    au  = longint'({32'd0, rn});
    bu  = longint'({32'd0, b});
    as_ = longint'($signed(rn));
    bs  = longint'($signed(b));
    cin = c ? 64'sd1 : 64'sd0;
    if (mul) begin
      res   = 32'(au * bu);
      m_res = res;
      m_wen = 1'b1;
      m_lat = MUL_CYCLES + 1;
      if (s) m_flags = {res[31], res == 32'd0, c, v};
      return;
    end
    arith = 1'b1;
    r     = 0;
    sr    = 0;
    res   = 32'd0;
    case (op)
      4'h2, 4'hA: begin r = au - bu;       sr = as_ - bs;       c = au >= bu;       end
      4'h3:       begin r = bu - au;       sr = bs - as_;       c = bu >= au;       end
      4'h4, 4'hB: begin r = au + bu;       sr = as_ + bs;       c = r >= 64'sd4294967296; end
      4'h5:       begin r = au + bu + cin; sr = as_ + bs + cin; c = r >= 64'sd4294967296; end
      4'h6:       begin r = au - bu - (1 - cin); sr = as_ - bs - (1 - cin); c = au >= bu + (1 - cin); end
      4'h7:       begin r = bu - au - (1 - cin); sr = bs - as_ - (1 - cin); c = bu >= au + (1 - cin); end
      default: begin
        arith = 1'b0;
        case (op)
          4'h0, 4'h8: res = rn & b;
          4'h1, 4'h9: res = rn ^ b;
          4'hC:       res = rn | b;
          4'hD:       res = b;
          4'hE:       res = rn & ~b;
          default:    res = ~b;
        endcase
        if (ws) c = cb;
      end
    endcase
    if (arith) begin
      res = r[31:0];
      v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    n = res[31];
    z = (res == 32'd0);
    if (s) m_flags = {n, z, c, v};
    m_res = res;
    m_wen = !((op == 4'h8) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB));
  endtask

  // Drives one instruction and waits (bounded) until it is accepted on an edge.
  task automatic applyStimulus(input logic [3:0] op, input logic s, input logic [3:0] cond,
                               input logic mul, input logic [31:0] rn, input logic [31:0] b,
                               input logic cb, input logic ws);
    int n;
    CTRL_aluop    = op;
    CTRL_setflags = s;
    CTRL_cond     = cond;
    CTRL_mul      = mul;
    RF_Rn         = rn;
    src2          = b;
    carryBit      = cb;
    was_shifted   = ws;
    in_valid      = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) compare("in_ready timeout", 32'(in_ready), 32'd1);
    modelExec(op, s, cond, mul, rn, b, cb, ws);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 60) begin
      tick();
      cycles++;
    end
    if (!out_valid) compare("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_res,
                             input logic exp_wen, input logic [3:0] exp_flags);
    compare({name, " out_valid"}, 32'(out_valid), 32'd1);
    compare({name, " result"}, alu_result, exp_res);
    compare({name, " write_en"}, 32'(write_en), 32'(exp_wen));
    compare({name, " flags"}, 32'(flags), 32'(exp_flags));
  endtask

  task automatic addVector(input string name, input logic [3:0] op, input logic s,
                           input logic [3:0] cond, input logic [31:0] rn, input logic [31:0] b,
                           input logic cb, input logic ws, input logic [31:0] res,
                           input logic wen, input logic [3:0] fl);
    vec_t t;
    t.name = name; t.op = op; t.s = s; t.cond = cond; t.rn = rn; t.b = b;
    t.cb = cb; t.ws = ws; t.exp_res = res; t.exp_wen = wen; t.exp_flags = fl;
    vecs.push_back(t);
  endtask

  initial begin
    int cyc;
    logic [31:0] corners[6];
    logic [31:0] ra, rb;
    logic [3:0]  rop, rcond;
    logic        rs, rmul;

    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF; corners[5] = 32'hFFFF_FFFE;

    // Flags chain from reset 0000; each row's expectation assumes the rows above.
    addVector("adds 5+7",       ADD_, 1, AL, 32'd5,          32'd7,          0, 0, 32'd12,         1, 4'b0000);
    addVector("subs 3-3",       SUB_, 1, AL, 32'd3,          32'd3,          0, 0, 32'd0,          1, 4'b0110);
    addVector("add eq",         ADD_, 0, EQ, 32'd1,          32'd1,          0, 0, 32'd2,          1, 4'b0110);
    addVector("add ne fail",    ADD_, 0, NE, 32'd1,          32'd1,          0, 0, 32'd0,          0, 4'b0110);
    addVector("adds ovf",       ADD_, 1, AL, 32'h7FFF_FFFF,  32'd1,          0, 0, 32'h8000_0000,  1, 4'b1001);
    addVector("movs shifted",   MOV_, 1, AL, 32'd0,          32'h8000_0000,  1, 1, 32'h8000_0000,  1, 4'b1011);
    addVector("movs unshifted", MOV_, 1, AL, 32'd0,          32'h8000_0000,  0, 0, 32'h8000_0000,  1, 4'b1011);
    addVector("movs c clear",   MOV_, 1, AL, 32'd0,          32'd1,          0, 1, 32'd1,          1, 4'b0001);
    addVector("cmp 1-2",        CMP_, 1, AL, 32'd1,          32'd2,          0, 0, 32'hFFFF_FFFF,  0, 4'b1000);
    addVector("sbcs c=0",       SBC_, 1, AL, 32'd10,         32'd3,          0, 0, 32'd6,          1, 4'b0010);
    addVector("adcs carry",     ADC_, 1, AL, 32'hFFFF_FFFF,  32'd0,          0, 0, 32'd0,          1, 4'b0110);
    addVector("rsbs 3-5",       RSB_, 1, AL, 32'd5,          32'd3,          0, 0, 32'hFFFF_FFFE,  1, 4'b1000);
    addVector("teq equal",      TEQ_, 1, AL, 32'h0000_00F0,  32'h0000_00F0,  1, 0, 32'd0,          0, 4'b0100);
    addVector("bic",            BIC_, 0, AL, 32'h0000_00FF,  32'h0000_000F,  0, 0, 32'h0000_00F0,  1, 4'b0100);
    addVector("mvns ge",        MVN_, 1, GE, 32'd0,          32'd0,          0, 0, 32'hFFFF_FFFF,  1, 4'b1000);
    addVector("adds lt",        ADD_, 1, LT, 32'd1,          32'd2,          0, 0, 32'd3,          1, 4'b0000);
    addVector("adds gt wrap",   ADD_, 1, GT, 32'h8000_0000,  32'h8000_0000,  0, 0, 32'd0,          1, 4'b0111);
    addVector("orr hi fail",    ORR_, 0, HI, 32'd1,          32'd2,          0, 0, 32'd0,          0, 4'b0111);
    addVector("eor ls",         EOR_, 0, LS, 32'h0000_FF00,  32'h0000_0FF0,  0, 0, 32'h0000_F0F0,  1, 4'b0111);

    // Reset state.
    #3 RESET_N = 1'b0;
    tick();
    tick();
    compare("reset out_valid", 32'(out_valid), 32'd0);
    compare("reset result", alu_result, 32'd0);
    compare("reset write_en", 32'(write_en), 32'd0);
    compare("reset flags", 32'(flags), 32'd0);
    compare("reset in_ready", 32'(in_ready), 32'd1);
    RESET_N = 1'b1;
    m_flags = 4'b0000;
    tick();

    // Directed vector table, one-cycle ALU path.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].s, vecs[i].cond, 1'b0, vecs[i].rn, vecs[i].b,
                    vecs[i].cb, vecs[i].ws);
      waitResult(cyc);
      compare({vecs[i].name, " latency"}, 32'(cyc), 32'd0);
      checkOutput(vecs[i].name, vecs[i].exp_res, vecs[i].exp_wen, vecs[i].exp_flags);
    end

    // MULS 1234*5678 with C=V=1 beforehand: only N/Z may change.
    applyStimulus(4'h0, 1, AL, 1, 32'd1234, 32'd5678, 0, 0);
    for (int i = 1; i <= MUL_CYCLES + 1; i++) begin
      if (i <= MUL_CYCLES) begin
        compare("mul busy in_ready", 32'(in_ready), 32'd0);
        compare("mul busy out_valid", 32'(out_valid), 32'd0);
      end
      tick();
    end
    checkOutput("muls", 32'd7006652, 1'b1, 4'b0011);

    // MUL with a failing condition completes like a failed ALU op.
    applyStimulus(4'h0, 1, EQ, 1, 32'd3, 32'd4, 0, 0);
    waitResult(cyc);
    compare("mul cond fail latency", 32'(cyc), 32'd0);
    checkOutput("mul cond fail", 32'd0, 1'b0, 4'b0011);

    // Backpressure: first beat held, second accepted on the draining edge.
    tick();
    out_ready = 1'b0;
    applyStimulus(ADD_, 0, AL, 0, 32'd2, 32'd3, 0, 0);
    CTRL_aluop = ADD_; CTRL_setflags = 1'b0; CTRL_cond = AL; CTRL_mul = 1'b0;
    RF_Rn = 32'd10; src2 = 32'd20; carryBit = 1'b0; was_shifted = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compare("bp in_ready low", 32'(in_ready), 32'd0);
      checkOutput("bp hold", 32'd5, 1'b1, m_flags);
      tick();
    end
    out_ready = 1'b1;
    #1;
    compare("bp in_ready high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp second", 32'd30, 1'b1, m_flags);
    tick();
    compare("bp drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL aborts it silently.
    applyStimulus(4'h0, 0, AL, 1, 32'd99, 32'd77, 0, 0);
    repeat (10) tick();
    RESET_N = 1'b0;
    #1;
    compare("midmul reset out_valid", 32'(out_valid), 32'd0);
    compare("midmul reset flags", 32'(flags), 32'd0);
    compare("midmul reset result", alu_result, 32'd0);
    m_flags = 4'b0000;
    tick();
    RESET_N = 1'b1;
    tick();
    compare("post reset in_ready", 32'(in_ready), 32'd1);
    repeat (MUL_CYCLES + 4) tick();
    compare("no stale mul beat", 32'(out_valid), 32'd0);
    applyStimulus(ADD_, 0, AL, 0, 32'd2, 32'd2, 0, 0);
    waitResult(cyc);
    checkOutput("post reset add", 32'd4, 1'b1, 4'b0000);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 200; i++) begin
      rop   = 4'($urandom_range(0, 15));
      rs    = 1'($urandom_range(0, 1));
      rcond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : AL;
      rmul  = ($urandom_range(0, 9) == 0);
      ra    = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      rb    = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      applyStimulus(rop, rs, rcond, rmul, ra, rb, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      waitResult(cyc);
      compare("rand latency", 32'(cyc), 32'(m_lat));
      checkOutput("rand", m_res, m_wen, m_flags);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          tick();
          checkOutput("rand hold", m_res, m_wen, m_flags);
        end
        out_ready = 1'b1;
      end
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
